// File: rtl/crc_frame_receiver_pkg.sv
// Shared constants and state encoding for the RTS/CTS CRC frame link.
// Imported by the receiver, its serial CRC engine and the link interface.
package crc_frame_receiver_pkg;

  localparam int DATA_W  = 50;
  localparam int CRC_W   = 16;
  localparam int FRAME_W = DATA_W + CRC_W;
  localparam int CNT_W   = 8;
  localparam int IDX_W   = 7;

  localparam logic [CRC_W-1:0] CRC_POLY = 16'h8005;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    IDLE,
    CHECK,
    DONE
  } state_t;

endpackage

// File: rtl/crc_frame_receiver_if.sv
// Handshake and frame bus between the CRC frame sender (master) and receiver (slave).
// The sender drives RTS and the frame; the receiver answers with CTS.
interface crc_frame_receiver_if;
  import crc_frame_receiver_pkg::*;

  logic               RTS;
  logic [0:FRAME_W-1] in;
  logic               CTS;

  modport master (
    output RTS,
    output in,
    input  CTS
  );

  modport slave (
    input  RTS,
    input  in,
    output CTS
  );

endinterface

// File: rtl/crc_frame_receiver_crc16.sv
// Bit-serial CRC-16 engine (MSB first, init 0, no reflection, no final XOR).
// Shared by the sender-side generator and the receiver-side checker.
module crc16_serial
  import crc_frame_receiver_pkg::*;
#(
  parameter logic [CRC_W-1:0] POLY = CRC_POLY
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             bit_in,
  output logic [CRC_W-1:0] crc
);

  logic fb;

  assign fb = crc[CRC_W-1] ^ bit_in;

  // clr takes precedence over en so a new frame always starts from zero
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      crc <= '0;
    end else if (en) begin
      crc <= {crc[CRC_W-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
  end

endmodule

// File: rtl/crc_frame_receiver.sv
// Receiving end of the RTS/CTS CRC frame link: captures a 66-bit frame on a
// falling RTS, checks it bit-serially and reports data with a pass/fail flag.
module crc_frame_receiver
  import crc_frame_receiver_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  crc_frame_receiver_if.slave  link,
  output logic [DATA_W-1:0]    data_out,
  output logic                 crc_ok,
  output logic                 frame_valid,
  output logic [CNT_W-1:0]     frame_cnt,
  output logic [CNT_W-1:0]     err_cnt
);

  state_t             state;
  state_t             next_state;
  logic               rts_q;
  logic               cts_q;
  logic [0:FRAME_W-1] frame_q;
  logic [IDX_W-1:0]   bit_idx;
  logic [CRC_W-1:0]   crc;
  logic               capture;
  logic               crc_clr;
  logic               crc_en;

  assign link.CTS = cts_q;

  crc16_serial #(
    .POLY (CRC_POLY)
  ) u_crc (
    .clk    (clk),
    .rst    (rst),
    .clr    (crc_clr),
    .en     (crc_en),
    .bit_in (frame_q[bit_idx]),
    .crc    (crc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // A frame is marked by RTS falling while we are idle and already advertising CTS
  always_comb begin
    next_state = state;
    capture    = 1'b0;
    crc_clr    = 1'b0;
    crc_en     = 1'b0;
    case (state)
      IDLE: begin
        if (cts_q && rts_q && !link.RTS) begin
          capture    = 1'b1;
          crc_clr    = 1'b1;
          next_state = CHECK;
        end
      end
      CHECK: begin
        crc_en = 1'b1;
        if (bit_idx == LAST_IDX) begin
          next_state = DONE;
        end
      end
      DONE: begin
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // CTS is registered from next_state so it rises on the edge that leaves DONE
  always_ff @(posedge clk) begin
    if (rst) begin
      rts_q       <= 1'b0;
      cts_q       <= 1'b0;
      frame_q     <= '0;
      bit_idx     <= '0;
      data_out    <= '0;
      crc_ok      <= 1'b0;
      frame_valid <= 1'b0;
      frame_cnt   <= '0;
      err_cnt     <= '0;
    end else begin
      rts_q       <= link.RTS;
      cts_q       <= (next_state == IDLE);
      frame_valid <= 1'b0;
      if (capture) begin
        frame_q <= link.in;
        bit_idx <= '0;
      end else if (crc_en) begin
        bit_idx <= bit_idx + 1'b1;
      end
      if (state == DONE) begin
        frame_valid <= 1'b1;
        crc_ok      <= (crc == '0);
        data_out    <= frame_q[0:DATA_W-1];
        frame_cnt   <= frame_cnt + 1'b1;
        if (crc != '0) begin
          err_cnt <= err_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_receiver.sv
// Self-checking bench for crc_frame_receiver: table-driven frames plus
// hand-written sequences for RTS noise, mid-check reset and counter wrap.
module tb_crc_frame_receiver;
  import crc_frame_receiver_pkg::*;

  logic clk = 1'b0;
  logic rst;
  logic [DATA_W-1:0] data_out;
  logic              crc_ok;
  logic              frame_valid;
  logic [CNT_W-1:0]  frame_cnt;
  logic [CNT_W-1:0]  err_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  crc_frame_receiver_if link ();

  crc_frame_receiver dut (
    .clk         (clk),
    .rst         (rst),
    .link        (link),
    .data_out    (data_out),
    .crc_ok      (crc_ok),
    .frame_valid (frame_valid),
    .frame_cnt   (frame_cnt),
    .err_cnt     (err_cnt)
  );

  typedef struct {
    logic [DATA_W-1:0] data;
    logic [DATA_W-1:0] dataXor;
    logic [CRC_W-1:0]  crcXor;
    logic              expOk;
  } vec_t;

  vec_t vecs [8];

  // Reference CRC by polynomial long division of data * x^16
  function automatic logic [CRC_W-1:0] crcRef(input logic [DATA_W-1:0] d);
    logic [FRAME_W-1:0] m;
    logic [FRAME_W-1:0] divisor;
    m       = {d, 16'h0000};
    divisor = 66'h18005;
    for (int b = FRAME_W - 1; b >= CRC_W; b--) begin
      if (m[b]) m = m ^ (divisor << (b - CRC_W));
    end
    return m[CRC_W-1:0];
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", name, actual, expected);
    end
  endtask

  task automatic startFrame(input logic [0:FRAME_W-1] frame);
    int n;
    n = 0;
    while (link.CTS !== 1'b1 && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("cts_ready", 64'(link.CTS), 64'(1));
    link.in  = frame;
    link.RTS = 1'b1;
    @(negedge clk);
    link.RTS = 1'b0;
  endtask

  task automatic waitDone(input bit toggle, output int validAt, output int lowCnt);
    validAt = 0;
    lowCnt  = 0;
    for (int i = 1; i <= 200; i++) begin
      @(negedge clk);
      if (i == 1) link.in = ~link.in;
      if (link.CTS === 1'b0) lowCnt++;
      if (frame_valid === 1'b1) begin
        validAt = i;
        break;
      end
      if (toggle) begin
        if (i < 66) link.RTS = ~link.RTS;
        else if (i == 66) link.RTS = 1'b1;
        else link.RTS = 1'b0;
      end
    end
  endtask

  task automatic applyStimulus(input logic [0:FRAME_W-1] frame, input bit toggle,
                               output int validAt, output int lowCnt);
    startFrame(frame);
    waitDone(toggle, validAt, lowCnt);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [0:FRAME_W-1] frame;
    logic [DATA_W-1:0]  d;
    int validAt;
    int lowCnt;
    int expFrames;
    int expErrs;
    int extra;

    vecs[0] = '{50'h0,              50'h0,             16'h0000, 1'b1};
    vecs[1] = '{50'h3_FFFF_FFFF_FFFF, 50'h0,           16'h0000, 1'b1};
    vecs[2] = '{50'h3_FFFF_FFFF_FFFF, 50'h0,           16'h0001, 1'b0};
    vecs[3] = '{50'h0_0000_0000_0001, 50'h0,           16'h0000, 1'b1};
    vecs[4] = '{50'h2_AAAA_AAAA_AAAA, 50'h0,           16'h0000, 1'b1};
    vecs[5] = '{50'h1_5555_5555_5555, 50'h0,           16'h8000, 1'b0};
    vecs[6] = '{50'h0_1234_5678_9ABC, 50'h0,           16'h0000, 1'b1};
    vecs[7] = '{50'h0_1234_5678_9ABC, 50'h2_0000_0000_0000, 16'h0000, 1'b0};

    rst      = 1'b1;
    link.RTS = 1'b0;
    link.in  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_cts", 64'(link.CTS), 64'(0));
    checkOutput("rst_data_out", 64'(data_out), 64'(0));
    checkOutput("rst_crc_ok", 64'(crc_ok), 64'(0));
    checkOutput("rst_frame_valid", 64'(frame_valid), 64'(0));
    checkOutput("rst_frame_cnt", 64'(frame_cnt), 64'(0));
    checkOutput("rst_err_cnt", 64'(err_cnt), 64'(0));
    rst = 1'b0;
    checkOutput("cts_before_first_clk", 64'(link.CTS), 64'(0));
    @(negedge clk);
    checkOutput("cts_after_release", 64'(link.CTS), 64'(1));

    expFrames = 0;
    expErrs   = 0;
    for (int v = 0; v < 8; v++) begin
      frame = {vecs[v].data ^ vecs[v].dataXor, crcRef(vecs[v].data) ^ vecs[v].crcXor};
      applyStimulus(frame, 1'b0, validAt, lowCnt);
      expFrames++;
      if (!vecs[v].expOk) expErrs++;
      checkOutput("vec_valid_latency", 64'(validAt), 64'(68));
      checkOutput("vec_cts_low_cycles", 64'(lowCnt), 64'(67));
      checkOutput("vec_crc_ok", 64'(crc_ok), 64'(vecs[v].expOk));
      checkOutput("vec_data_out", 64'(data_out), 64'(vecs[v].data ^ vecs[v].dataXor));
      checkOutput("vec_frame_cnt", 64'(frame_cnt), 64'(expFrames));
      checkOutput("vec_err_cnt", 64'(err_cnt), 64'(expErrs));
      @(negedge clk);
      checkOutput("vec_valid_pulse_width", 64'(frame_valid), 64'(0));
      checkOutput("vec_crc_ok_held", 64'(crc_ok), 64'(vecs[v].expOk));
    end

    // RTS toggles through CHECK and falls in the DONE cycle: only one frame counts
    frame = {50'h3_FFFF_FFFF_FFFF, crcRef(50'h3_FFFF_FFFF_FFFF)};
    applyStimulus(frame, 1'b1, validAt, lowCnt);
    expFrames++;
    checkOutput("toggle_valid_latency", 64'(validAt), 64'(68));
    checkOutput("toggle_crc_ok", 64'(crc_ok), 64'(1));
    checkOutput("toggle_frame_cnt", 64'(frame_cnt), 64'(expFrames));
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (frame_valid === 1'b1 || link.CTS !== 1'b1) extra++;
    end
    checkOutput("toggle_no_extra_capture", 64'(extra), 64'(0));
    checkOutput("toggle_frame_cnt_after", 64'(frame_cnt), 64'(expFrames));

    // Reset at bit index 30 abandons the frame; RTS stays low through release
    startFrame(frame);
    extra = 0;
    for (int i = 1; i <= 31; i++) begin
      @(negedge clk);
      if (frame_valid === 1'b1) extra++;
    end
    rst = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (frame_valid === 1'b1) extra++;
    end
    rst = 1'b0;
    checkOutput("midrst_cts_first_cycle", 64'(link.CTS), 64'(0));
    checkOutput("midrst_frame_cnt", 64'(frame_cnt), 64'(0));
    checkOutput("midrst_err_cnt", 64'(err_cnt), 64'(0));
    @(negedge clk);
    checkOutput("midrst_cts_second_cycle", 64'(link.CTS), 64'(1));
    repeat (10) begin
      @(negedge clk);
      if (frame_valid === 1'b1) extra++;
    end
    checkOutput("midrst_no_valid", 64'(extra), 64'(0));
    checkOutput("rts_low_release_frame_cnt", 64'(frame_cnt), 64'(0));

    // 257 back-to-back good frames wrap the frame counter to 1
    for (int k = 0; k < 257; k++) begin
      d     = DATA_W'({$urandom(), $urandom()});
      frame = {d, crcRef(d)};
      applyStimulus(frame, 1'b0, validAt, lowCnt);
      checkOutput("wrap_valid_latency", 64'(validAt), 64'(68));
      checkOutput("wrap_crc_ok", 64'(crc_ok), 64'(1));
    end
    checkOutput("wrap_frame_cnt", 64'(frame_cnt), 64'(1));
    checkOutput("wrap_err_cnt", 64'(err_cnt), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/crc_frame_receiver.md
Name: crc_frame_receiver

Overview:
- Receiving end of the RTS/CTS CRC frame link.
- Accepts 66-bit frames (50 data bits followed by 16 CRC bits) from the sender.
- Checks each frame with a bit-serial CRC-16 and presents the data with a pass/fail flag.
- Sits opposite the sender; drives CTS and observes RTS.

Parameters:
- DATA_W, 50, payload width in bits.
- CRC_W, 16, CRC width in bits; frame width = DATA_W+CRC_W = 66.
- POLY, 16'h8005, CRC generator polynomial (implicit x^16 term); register init 0, no reflection, no final XOR.
- CNT_W, 8, width of frame and error counters.

Ports:
- clk  input  1  system clock, all logic on posedge.
- rst  input  1  synchronous active-high reset.
- RTS  input  1  sender request; a high-to-low transition marks a valid frame on in.
- in  input  [0:65]  frame; in[0:49] is data (in[0] first/MSB), in[50:65] is the CRC.
- CTS  output  1  clear-to-send; high only while idle and ready to capture.
- data_out  output  [49:0]  captured payload; data_out[49] = in[0].
- crc_ok  output  1  result of last check, valid with frame_valid and held until the next result.
- frame_valid  output  1  one-cycle pulse when a check completes.
- frame_cnt  output  [CNT_W-1:0]  frames checked, wraps modulo 2^CNT_W.
- err_cnt  output  [CNT_W-1:0]  frames failing CRC, wraps modulo 2^CNT_W.

Behaviour:
- Reset values (rst=1 at posedge): CTS=0, data_out=0, crc_ok=0, frame_valid=0, frame_cnt=0, err_cnt=0, rts_q=0, state=IDLE.
  - CTS rises on the first clock after rst deasserts.
  - rst mid-CHECK abandons the frame; no pulse is produced and no counter changes.
- rts_q is RTS registered each cycle. Capture condition: state=IDLE, CTS=1, rts_q=1 and RTS=0.
  - A low RTS with rts_q=0, e.g. after reset, is not a frame.
- States:
  - IDLE: CTS=1. On the capture condition: latch in into an internal 66-bit shift register, clear the CRC register to 0, set bit index to 0, deassert CTS, go to CHECK.
  - CHECK: CTS=0. Shift one frame bit per cycle, in[0] first, into the CRC-16 LFSR over all 66 bits (data then received CRC). After bit 65, go to DONE. Duration is exactly 66 cycles.
  - DONE: one cycle.
    - crc_ok = (remainder==0); data_out = latched in[0:49]; frame_valid=1.
    - frame_cnt += 1; err_cnt += 1 if remainder!=0.
    - Go to IDLE; CTS rises the same edge.
- Latency: the capture edge is T. frame_valid is high for the cycle after edge T+67. CTS is low from T+1 through T+67.
- RTS activity while CTS=0 is ignored. Frame contents on in are don't-care outside the capture cycle.
- Simultaneous events:
  - rst has priority over everything.
  - A falling RTS in the DONE cycle is ignored, because CTS is not yet high.
- Counters wrap (255 -> 0) silently.
- CRC step per bit b: fb = crc[15]^b; crc = {crc[14:0],1'b0} ^ (fb ? POLY : 0).

Decomposition:
- Shared package holds:
  - DATA_W, CRC_W, FRAME_W=66 and the polynomial constant 16'h8005.
  - The state enum {IDLE, CHECK, DONE}.
- One sub-module, crc16_serial: clk, rst, clr, en, bit_in, crc[15:0], computing the step above. The sender-side CRC generator uses the same sub-module.
- Top level holds the FSM, capture register, bit index (7 bits, 0..65) and counters.

Test Plan:
- Reset: hold rst 3 cycles -> all outputs 0, CTS=0. After release, CTS=1 one cycle later.
- All-zero frame (data 0, CRC 16'h0000) with one RTS 1->0 pulse -> CTS low 67 cycles; frame_valid pulse; crc_ok=1, data_out=0, frame_cnt=1, err_cnt=0.
- Frame data=50'h3_FFFF_FFFF_FFFF with the CRC from the reference model -> crc_ok=1. The same frame with in[65] flipped -> crc_ok=0 and err_cnt increments by 1.
- RTS toggling during CHECK, and RTS held low through reset release -> no extra captures; frame_cnt increments exactly once per accepted frame.
- rst asserted at bit index 30 of CHECK -> no frame_valid; counters 0; CTS=1 on the second cycle after rst drops.
- 257 back-to-back good frames -> frame_cnt=1 (wrapped), err_cnt=0. Each next frame is captured on the first RTS fall after CTS rises.
